// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// The state encoding is fixed so it can be probed on a bus or in a waveform.
package imem_loader_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: collects bytes into one 32-bit word.
// The flush word already contains the byte being pushed, with unfilled upper lanes zeroed.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              i_srst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_last_lane,
  output logic [WORD_W-1:0] o_flush_word
);

  logic [CNT_W-1:0]  r_byte_cnt;
  logic [WORD_W-1:0] r_pack;
  logic [WORD_W-1:0] w_merged;

  // Lanes below the fill pointer keep their byte, the pointed lane takes the
  // incoming byte, and lanes above read as zero.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign w_merged[gi*BYTE_W +: BYTE_W] =
        (CNT_W'(gi) < r_byte_cnt)  ? r_pack[gi*BYTE_W +: BYTE_W] :
        (CNT_W'(gi) == r_byte_cnt) ? i_data : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_srst || i_clear) begin
      r_byte_cnt <= '0;
      r_pack     <= '0;
    end else if (i_push) begin
      r_pack     <= w_merged;
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
    end
  end

  assign o_last_lane  = (r_byte_cnt == CNT_W'(WORD_BYTES - 1));
  assign o_flush_word = w_merged;

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wise program into instruction memory as 32-bit words,
// then pulses the chip's start input with the configured entry point.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ENTRY_POINT = 32'h0000_0028,
  parameter int          MAX_WORDS   = 256,
  localparam int         WC_W        = $clog2(MAX_WORDS) + 1
) (
  input  logic              clk,
  input  logic              INT,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              chip_int,
  output logic [31:0]       entry_point,
  output logic              done,
  output logic              err,
  output logic [WC_W-1:0]   word_count
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [WC_W-1:0]   r_word_count;
  logic              r_chip_int;
  logic [31:0]       r_entry_point;
  logic              r_done;
  logic              r_err;
  logic              r_last_flag;

  logic              w_accept;
  logic              w_flush;
  logic              w_overflow;
  logic              w_write_done;
  logic              w_last_lane;
  logic [WORD_W-1:0] w_flush_word;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .i_srst       (INT),
    .i_push       (w_accept),
    .i_data       (in_data),
    .i_clear      (w_write_done),
    .o_last_lane  (w_last_lane),
    .o_flush_word (w_flush_word)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_flush      = 1'b0;
    w_overflow   = 1'b0;
    w_write_done = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (in_valid) begin
          // A full memory refuses the byte outright rather than dropping it silently.
          if (r_word_count == WC_W'(MAX_WORDS)) begin
            w_overflow   = 1'b1;
            w_state_next = ST_ERR;
          end else begin
            w_accept = 1'b1;
            if (w_last_lane || in_last) begin
              w_flush      = 1'b1;
              w_state_next = ST_WRITE;
            end
          end
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          w_write_done = 1'b1;
          w_state_next = r_last_flag ? ST_DONE : ST_COLLECT;
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (INT) begin
      r_state       <= ST_COLLECT;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= BASE_ADDR;
      r_mem_wdata   <= '0;
      r_word_count  <= '0;
      r_chip_int    <= 1'b0;
      r_entry_point <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_last_flag   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_chip_int <= 1'b0;
      if (w_flush) begin
        r_mem_wdata <= w_flush_word;
        r_last_flag <= in_last;
        r_mem_we    <= 1'b1;
      end
      if (w_write_done) begin
        r_mem_we     <= 1'b0;
        r_mem_addr   <= r_mem_addr + 32'd4;
        r_word_count <= r_word_count + WC_W'(1);
        // Entering DONE: start the chip exactly once.
        if (r_last_flag) begin
          r_chip_int    <= 1'b1;
          r_entry_point <= ENTRY_POINT;
          r_done        <= 1'b1;
        end
      end
      if (w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready    = (r_state == ST_COLLECT);
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign chip_int    = r_chip_int;
  assign entry_point = r_entry_point;
  assign done        = r_done;
  assign err         = r_err;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-stream model predicts every memory
// write and one negedge monitor checks the DUT against it each cycle.
module tb_imem_loader;

  localparam int          MAXW  = 2;
  localparam logic [31:0] ENTRY = 32'h0000_0028;

  logic        clk = 1'b0;
  logic        INT = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        mem_ready = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        chip_int;
  logic [31:0] entry_point;
  logic        done;
  logic        err;
  logic [1:0]  word_count;

  imem_loader #(
    .BASE_ADDR   (32'h0000_0000),
    .ENTRY_POINT (ENTRY),
    .MAX_WORDS   (MAXW)
  ) u_dut (
    .clk         (clk),
    .INT         (INT),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .chip_int    (chip_int),
    .entry_point (entry_point),
    .done        (done),
    .err         (err),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: expected writes as {addr, word}, built from the accepted byte stream.
  logic [63:0] exp_q[$];
  logic [31:0] m_word;
  logic [31:0] m_addr;
  int          m_n;

  task automatic model_reset();
    exp_q.delete();
    m_word = 32'h0;
    m_addr = 32'h0;
    m_n    = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic last);
    m_word = m_word | ({24'h0, b} << (8 * m_n));
    m_n++;
    if (m_n == 4 || last) begin
      exp_q.push_back({m_addr, m_word});
      m_addr = m_addr + 32'd4;
      m_word = 32'h0;
      m_n    = 0;
    end
  endtask

  // Monitor: owns the read index, the log of completed writes and the start-pulse count.
  int          rd_idx = 0;
  int          pulses = 0;
  logic        prev_int = 1'b0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    if (INT) begin
      rd_idx   = 0;
      pulses   = 0;
      prev_int = 1'b0;
      log_addr.delete();
      log_data.delete();
    end else begin
      if (mem_we) begin
        check("in_ready_during_write", {31'h0, in_ready}, 32'h0);
        if (rd_idx >= exp_q.size()) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr=0x%08h data=0x%08h, required no write", mem_addr, mem_wdata);
        end else begin
          check("write_addr", mem_addr, exp_q[rd_idx][63:32]);
          check("write_data", mem_wdata, exp_q[rd_idx][31:0]);
        end
        if (mem_ready) begin
          $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
          rd_idx++;
        end
      end
      if (chip_int) begin
        pulses++;
        check("entry_point_at_start", entry_point, ENTRY);
        check("chip_int_one_cycle", {31'h0, prev_int}, 32'h0);
      end
      prev_int = chip_int;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    INT      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_reset();
    tick();
    tick();
    INT = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    for (int t = 0; t < 40; t++) begin
      ok = in_ready;
      tick();
      if (ok) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("byte_accepted", {31'h0, ok}, 32'h1);
    if (ok) model_byte(b, last);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 40; t++) begin
      if (done) break;
      tick();
    end
    check("done_reached", {31'h0, done}, 32'h1);
  endtask

  logic [7:0] prog1[8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
  logic [7:0] prog5[5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h7F};

  initial begin
    model_reset();
    do_reset();

    // Reset state.
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_word_count", {30'h0, word_count}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_chip_int", {31'h0, chip_int}, 32'h0);
    check("rst_entry_point", entry_point, 32'h0);

    // Two full words, memory always ready.
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
    wait_done();
    repeat (3) tick();
    check("p1_log_n", log_addr.size(), 32'd2);
    check("p1_addr0", log_addr[0], 32'h0);
    check("p1_data0", log_data[0], 32'h0050_0513);
    check("p1_addr1", log_addr[1], 32'h4);
    check("p1_data1", log_data[1], 32'h0060_0593);
    check("p1_word_count", {30'h0, word_count}, 32'd2);
    check("p1_pulses", pulses, 32'd1);
    check("p1_entry_point", entry_point, ENTRY);
    check("p1_in_ready", {31'h0, in_ready}, 32'h0);

    // Partial final word is zero-filled.
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1), i == 5);
    wait_done();
    tick();
    check("p2_data0", log_data[0], 32'h0403_0201);
    check("p2_addr1", log_addr[1], 32'h4);
    check("p2_data1", log_data[1], 32'h0000_0605);

    // Five-cycle stall on the first write.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("stall_mem_we", {31'h0, mem_we}, 32'h1);
      check("stall_mem_addr", mem_addr, 32'h0);
      check("stall_mem_wdata", mem_wdata, 32'h0403_0201);
      check("stall_in_ready", {31'h0, in_ready}, 32'h0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    check("stall_done_we", {31'h0, mem_we}, 32'h0);
    check("stall_done_wc", {30'h0, word_count}, 32'd1);
    check("stall_done_ready", {31'h0, in_ready}, 32'h1);
    check("stall_log_n", log_addr.size(), 32'd1);

    // Reset asserted during a pending write aborts it.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1), 1'b0);
    check("abort_pending_addr", mem_addr, 32'h4);
    INT = 1'b1;
    model_reset();
    tick();
    INT = 1'b0;
    check("abort_mem_we", {31'h0, mem_we}, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_word_count", {30'h0, word_count}, 32'h0);
    check("abort_in_ready", {31'h0, in_ready}, 32'h1);
    mem_ready = 1'b1;
    send_byte(8'hA0, 1'b0);
    send_byte(8'hB1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hD3, 1'b1);
    wait_done();
    tick();
    check("reload_log_n", log_addr.size(), 32'd1);
    check("reload_addr", log_addr[0], 32'h0);
    check("reload_data", log_data[0], 32'hD3C2_B1A0);

    // Overflow: a byte offered with memory full is refused.
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
    for (int t = 0; t < 10; t++) begin
      if (word_count == 2'd2 && !mem_we) break;
      tick();
    end
    check("ovf_pre_wc", {30'h0, word_count}, 32'd2);
    check("ovf_pre_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("ovf_err", {31'h0, err}, 32'h1);
      check("ovf_in_ready", {31'h0, in_ready}, 32'h0);
      check("ovf_word_count", {30'h0, word_count}, 32'd2);
      check("ovf_mem_we", {31'h0, mem_we}, 32'h0);
    end
    in_valid = 1'b0;
    check("ovf_log_n", log_addr.size(), 32'd2);
    check("ovf_data0", log_data[0], 32'h1312_1110);
    check("ovf_data1", log_data[1], 32'h1716_1514);

    // Gapped input, then bytes after done are ignored.
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_byte(prog5[i], i == 4);
      tick();
    end
    wait_done();
    tick();
    check("gap_data0", log_data[0], 32'hDEAD_BEEF);
    check("gap_addr1", log_addr[1], 32'h4);
    check("gap_data1", log_data[1], 32'h0000_007F);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("post_done_in_ready", {31'h0, in_ready}, 32'h0);
      check("post_done_chip_int", {31'h0, chip_int}, 32'h0);
      check("post_done_done", {31'h0, done}, 32'h1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check("post_done_pulses", pulses, 32'd1);
    check("post_done_log_n", log_addr.size(), 32'd2);
    check("post_done_entry", entry_point, ENTRY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
